// File: rtl/mem_wb_pkg.sv
// Shared slot/writeback types and the writeback resolve function for the MEM->WB pipeline.
package mem_wb_pkg;

  // Slots are sized for the widest supported datapath; narrower instances zero-extend
  // on entry and truncate on exit, so the constant-zero high bits drop out in synthesis.
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_ADDR_W = 8;
  localparam int unsigned LINK_REG_DEFAULT = 31;

  typedef logic [MAX_DATA_W-1:0] data_t;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    logic  regwrite;
    logic  memtoreg;
    logic  link;
    data_t readdata;
    data_t aluresult;
    data_t pcadd;
    addr_t rd;
  } slot_t;

  typedef struct packed {
    logic  en;
    addr_t addr;
    data_t data;
  } wb_t;

  // Link outranks memtoreg; writes to $0 never assert the enable.
  function automatic wb_t wb_resolve(input slot_t s, input addr_t link_reg);
    wb_t r;
    r.addr = s.link ? link_reg : s.rd;
    r.data = s.link ? s.pcadd : (s.memtoreg ? s.readdata : s.aluresult);
    r.en   = s.valid & s.regwrite & (r.addr != '0);
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One MEM/WB stage register: synchronous Rst > Flush > Stall > load.
module mem_wb_slot
  import mem_wb_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  Stall,
  input  logic  Flush,
  input  slot_t d,
  output slot_t q
);

  // Flush clears the whole slot, not just valid, so dead payload never lingers.
  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      q <= '0;
    end else if (!Stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// DEPTH-stage MEM->WB pipeline with final writeback resolution.
// Optional EX forwarding outputs from stage 0 are built when MEM_WB_FWD_EN is defined.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned DEPTH    = 1,
  parameter int unsigned LINK_REG = LINK_REG_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               In_Valid,
  input  logic               RegWrite_In,
  input  logic               MemToReg_In,
  input  logic               Link_In,
  input  logic [DATA_W-1:0]  DM_ReadData_In,
  input  logic [DATA_W-1:0]  ALU_Result_In,
  input  logic [DATA_W-1:0]  PC_AddResult_In,
  input  logic [RADDR_W-1:0] Rd_In,
  output logic               WB_En,
  output logic [RADDR_W-1:0] WB_Addr,
  output logic [DATA_W-1:0]  WB_Data,
  output logic               Out_Valid
`ifdef MEM_WB_FWD_EN
  ,
  output logic               Fwd_En,
  output logic [RADDR_W-1:0] Fwd_Addr,
  output logic [DATA_W-1:0]  Fwd_Data
`endif
);

  localparam addr_t LinkAddr = addr_t'(RADDR_W'(LINK_REG));

  slot_t in_slot;
  slot_t slot_q [DEPTH];
  wb_t   wb;

  always_comb begin
    in_slot           = '0;
    in_slot.valid     = In_Valid;
    in_slot.regwrite  = RegWrite_In;
    in_slot.memtoreg  = MemToReg_In;
    in_slot.link      = Link_In;
    in_slot.readdata  = data_t'(DM_ReadData_In);
    in_slot.aluresult = data_t'(ALU_Result_In);
    in_slot.pcadd     = data_t'(PC_AddResult_In);
    in_slot.rd        = addr_t'(Rd_In);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_slot
    if (g == 0) begin : gen_first
      mem_wb_slot u_slot (
        .Clk   (Clk),
        .Rst   (Rst),
        .Stall (Stall),
        .Flush (Flush),
        .d     (in_slot),
        .q     (slot_q[g])
      );
    end else begin : gen_chain
      mem_wb_slot u_slot (
        .Clk   (Clk),
        .Rst   (Rst),
        .Stall (Stall),
        .Flush (Flush),
        .d     (slot_q[g-1]),
        .q     (slot_q[g])
      );
    end
  end

  assign wb        = wb_resolve(slot_q[DEPTH-1], LinkAddr);
  assign WB_En     = wb.en;
  assign WB_Addr   = wb.addr[RADDR_W-1:0];
  assign WB_Data   = wb.data[DATA_W-1:0];
  assign Out_Valid = slot_q[DEPTH-1].valid;

  // High bits beyond DATA_W/RADDR_W are always zero.
  logic unused_wb;
  assign unused_wb = ^wb;

`ifdef MEM_WB_FWD_EN
  wb_t fwd;

  assign fwd      = wb_resolve(slot_q[0], LinkAddr);
  assign Fwd_En   = fwd.en;
  assign Fwd_Addr = fwd.addr[RADDR_W-1:0];
  assign Fwd_Data = fwd.data[DATA_W-1:0];

  logic unused_fwd;
  assign unused_fwd = ^fwd;
`endif

endmodule
